mobo_responder: RTL and testbench

//  Motherboard-side responder for the CPU memory command interface.
//  - Accepts CTRL_READ / CTRL_WRITE from the CPU initiator, services them against an internal word memory and reports progress on mobo_stat.
//  - Sits between the cpu block and main memory.
//  - Mirrors the initiator FSM that waits for MOBO_IDLE, issues a command, then waits for MOBO_DONE.

---
 rtl/mobo_responder.sv | 120 ++++++++++++
 tb/tb_mobo_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mobo_responder.sv
// Motherboard-side responder: accepts CPU READ/WRITE commands, services them
// against an internal word memory and reports IDLE/BUSY/DONE/ERR on mobo_stat.
// Ports: clk, rst (async, active-low), mobo_ctrl (command in),
//        mobo_stat (registered status out), addr_in, dat_in (CPU address/data),
//        dat_out (read data, held until the next committed READ).
// Optional: define MOBO_RESP_ADDR_CHECK_EN to flag out-of-range addresses
//           with MOBO_ERR instead of wrapping them modulo MEM_DEPTH.
module mobo_responder #(
  parameter int word_width = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  output logic [word_width-1:0] mobo_stat,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] dat_in,
  output logic [word_width-1:0] dat_out
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] CTRL_READ  = 2'd1;
  localparam logic [1:0] CTRL_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cmd_q;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] data_q;
  logic [CW-1:0]         cnt_q;
  logic [word_width-1:0] dout_q;

  logic [word_width-1:0] mem [MEM_DEPTH];

  logic          is_cmd;
  logic          match;
  logic          oor;
  logic          accept;
  logic          commit;
  logic          mem_we;
  logic          rd_en;
  logic [IW-1:0] idx;

  assign is_cmd = (mobo_ctrl == word_width'(CTRL_READ)) ||
                  (mobo_ctrl == word_width'(CTRL_WRITE));
  // Completion is held only while the CPU still presents the same command.
  assign match  = (mobo_ctrl == word_width'(cmd_q));
  assign idx    = addr_q[IW-1:0];

`ifdef MOBO_RESP_ADDR_CHECK_EN
  assign oor = (addr_q >= word_width'(MEM_DEPTH));
`else
  // High address bits alias onto the index range.
  logic unused_hi;
  assign unused_hi = ^addr_q[word_width-1:IW];
  assign oor       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (is_cmd) state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = oor ? S_ERR : S_DONE;
      S_DONE: if (!match) state_d = S_IDLE;
      S_ERR:  if (!match) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == S_IDLE) && is_cmd;
    commit = (state_q == S_BUSY) && (cnt_q == '0);
    mem_we = commit && (cmd_q == CTRL_WRITE) && !oor;
    rd_en  = commit && (cmd_q == CTRL_READ) && !oor;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      cmd_q  <= mobo_ctrl[1:0];
      addr_q <= addr_in;
      data_q <= dat_in;
      cnt_q  <= CW'(LATENCY - 1);
    end else if (state_q == S_BUSY && cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       dout_q <= '0;
    else if (rd_en) dout_q <= mem[idx];
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= data_q;
  end

  assign mobo_stat = word_width'(state_q);
  assign dat_out   = dout_q;

endmodule

// File: tb/tb_mobo_responder.sv
// Bench for mobo_responder: vector table, hand-written corner sequences
// and randomized traffic against a word-array reference model.
module tb_mobo_responder;

  localparam int MD  = 256;
  localparam int LAT = 2;
  localparam logic [31:0] NONE = 32'd0;
  localparam logic [31:0] RD   = 32'd1;
  localparam logic [31:0] WR   = 32'd2;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] mobo_ctrl;
  logic [31:0] mobo_stat;
  logic [31:0] addr_in;
  logic [31:0] dat_in;
  logic [31:0] dat_out;

  int nvec;
  int nmis;

  logic [31:0] mem_m [MD];
  logic [31:0] dout_m;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [31:0] rel;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [9];

  mobo_responder #(
    .word_width(32),
    .MEM_DEPTH (MD),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mobo_ctrl(mobo_ctrl),
    .mobo_stat(mobo_stat),
    .addr_in  (addr_in),
    .dat_in   (dat_in),
    .dat_out  (dat_out)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command from IDLE through completion and release.
  task automatic do_cmd(input logic [31:0] cmd, input logic [31:0] addr,
                        input logic [31:0] dat, input bit churn,
                        input logic [31:0] rel);
    bit err;
    int ix;
    ix  = int'(addr % MD);
    err = 1'b0;
`ifdef MOBO_RESP_ADDR_CHECK_EN
    err = (addr >= MD);
`endif
    if (!err) begin
      if (cmd == WR) mem_m[ix] = dat;
      else           dout_m    = mem_m[ix];
    end
    mobo_ctrl = cmd;
    addr_in   = addr;
    dat_in    = dat;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check("busy", mobo_stat, 32'd1);
      if (churn) begin
        addr_in   = $urandom;
        dat_in    = $urandom;
        mobo_ctrl = 32'($urandom_range(0, 3));
      end
    end
    tick();
    check("done", mobo_stat, err ? 32'd3 : 32'd2);
    check("dout", dat_out, dout_m);
    mobo_ctrl = rel;
    tick();
    check("release", mobo_stat, 32'd0);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] r;
    nvec      = 0;
    nmis      = 0;
    clk       = 1'b0;
    clk_en    = 1'b0;
    rst       = 1'b1;
    mobo_ctrl = NONE;
    addr_in   = '0;
    dat_in    = '0;
    dout_m    = '0;

    // Async reset with the clock stopped.
    #3 rst = 1'b0;
    #1;
    check("rst_stat", mobo_stat, 32'd0);
    check("rst_dout", dat_out, 32'd0);
    clk_en = 1'b1;
    #20 rst = 1'b1;
    tick();
    check("idle_after_rst", mobo_stat, 32'd0);

    tbl[0] = '{WR, 32'd3,   32'd5,        RD,   32'd0};
    tbl[1] = '{RD, 32'd3,   32'd0,        WR,   32'd5};
    tbl[2] = '{WR, 32'd1,   32'h1111,     RD,   32'd5};
    tbl[3] = '{RD, 32'd1,   32'd0,        NONE, 32'h1111};
    tbl[4] = '{WR, 32'd10,  32'hAB,       RD,   32'h1111};
    tbl[5] = '{RD, 32'd10,  32'd0,        WR,   32'hAB};
    tbl[6] = '{WR, 32'd255, 32'hFF00FF,   NONE, 32'hAB};
    tbl[7] = '{RD, 32'd255, 32'd0,        NONE, 32'hFF00FF};
    tbl[8] = '{RD, 32'd3,   32'd0,        NONE, 32'd5};
    for (int i = 0; i < 9; i++) begin
      do_cmd(tbl[i].cmd, tbl[i].addr, tbl[i].dat, 1'b0, tbl[i].rel);
      check("tbl_dout", dat_out, tbl[i].exp_dout);
    end

    // Unknown codes leave the responder idle.
    mobo_ctrl = 32'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("illegal_idle", mobo_stat, 32'd0);
    end
    mobo_ctrl = 32'd3;
    tick();
    check("code3_idle", mobo_stat, 32'd0);
    mobo_ctrl = NONE;
    tick();

    // Hold WRITE after DONE; data churn must not write again.
    mobo_ctrl = WR;
    addr_in   = 32'd40;
    dat_in    = 32'h4040;
    mem_m[40] = 32'h4040;
    for (int i = 0; i < LAT; i++) tick();
    tick();
    check("hold_done", mobo_stat, 32'd2);
    for (int i = 0; i < 10; i++) begin
      dat_in = 32'hDEAD0000 + 32'(i);
      tick();
      check("hold_stat", mobo_stat, 32'd2);
    end
    mobo_ctrl = NONE;
    tick();
    check("hold_release", mobo_stat, 32'd0);
    do_cmd(RD, 32'd40, 32'd0, 1'b0, NONE);
    check("hold_once", dat_out, 32'h4040);

    // Input churn during BUSY.
    do_cmd(WR, 32'd20, 32'h2020, 1'b1, NONE);
    mobo_ctrl = NONE;
    tick();
    do_cmd(RD, 32'd20, 32'd0, 1'b0, NONE);
    check("churn_rd", dat_out, 32'h2020);

    // Reset aborts an uncommitted write.
    do_cmd(WR, 32'd7, 32'h11, 1'b0, NONE);
    mobo_ctrl = WR;
    addr_in   = 32'd7;
    dat_in    = 32'd9;
    tick();
    check("abort_busy", mobo_stat, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_stat", mobo_stat, 32'd0);
    check("abort_dout", dat_out, 32'd0);
    dout_m    = '0;
    mobo_ctrl = NONE;
    #1 rst = 1'b1;
    tick();
    check("abort_idle", mobo_stat, 32'd0);
    do_cmd(RD, 32'd7, 32'd0, 1'b0, NONE);
    check("abort_mem", dat_out, 32'h11);

    // Out-of-range address.
    do_cmd(RD, 32'd5, 32'd0, 1'b0, NONE);
    do_cmd(RD, MD + 1, 32'd0, 1'b0, NONE);
`ifdef MOBO_RESP_ADDR_CHECK_EN
    check("range_dout", dat_out, 32'h1111 ^ 32'h1111 ^ mem_m[5]);
`else
    check("range_dout", dat_out, 32'h1111);
`endif

    // Preseed every word, then random traffic.
    for (int a = 0; a < MD; a++)
      do_cmd(WR, 32'(a), $urandom, 1'b0, NONE);
    for (int n = 0; n < 300; n++) begin
      c = 32'($urandom_range(1, 2));
      case ($urandom_range(0, 2))
        0:       r = NONE;
        1:       r = 32'd3 - c;
        default: r = 32'd7;
      endcase
      do_cmd(c, 32'($urandom_range(0, 2 * MD - 1)), $urandom,
             1'($urandom_range(0, 1)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
